// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the upstream 8-deep FIFO and its UART drain stage.
// master = drain stage (issues the read strobe), slave = FIFO (returns flag and data).
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (
    output fifo_rd,
    input  fifo_empty,
    input  fifo_data
  );

  modport slave (
    input  fifo_rd,
    output fifo_empty,
    output fifo_data
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains the upstream FIFO one byte at a time.
// Frame: start bit, data LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tx_enable,
  fifo_uart_tx_if.master      fifo,
  output logic                tx,
  output logic                busy,
  output logic                tx_done,
  output logic [15:0]         frame_count
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [15:0]      LAST_CNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      DONE_CNT = 16'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } state_t;

  state_t                state_r;
  logic [15:0]           cnt_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic                  parity_r;
  logic                  tx_r;
  logic                  fifo_rd_r;
  logic                  busy_r;
  logic                  tx_done_r;
  logic [15:0]           frame_count_r;

  logic                  start_ok_s;
  logic                  cnt_last_s;
  logic                  cnt_done_s;
  logic [DATA_WIDTH-1:0] next_shift_s;

  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

  assign start_ok_s = tx_enable & ~fifo.fifo_empty;
  assign cnt_last_s = (cnt_r == LAST_CNT);
  assign cnt_done_s = (cnt_r == DONE_CNT);

  // Shift register contents after the current data bit has been sent.
  always_comb begin
    next_shift_s = shift_r >> 1;
  end

  // Frame sequencer: state, baud counter, shifter and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 16'd0;
      bit_idx_r     <= '0;
      shift_r       <= '0;
      parity_r      <= 1'b0;
      tx_r          <= 1'b1;
      fifo_rd_r     <= 1'b0;
      busy_r        <= 1'b0;
      tx_done_r     <= 1'b0;
      frame_count_r <= 16'd0;
    end else begin
      fifo_rd_r <= 1'b0;
      tx_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tx_r  <= 1'b1;
          cnt_r <= 16'd0;
          if (start_ok_s) begin
            state_r   <= ST_FETCH;
            fifo_rd_r <= 1'b1;
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_FETCH: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          // FIFO data is registered, so it is only valid one cycle after the pop.
          shift_r   <= fifo.fifo_data;
          parity_r  <= even_parity(fifo.fifo_data);
          bit_idx_r <= '0;
          cnt_r     <= 16'd0;
          tx_r      <= 1'b0;
          state_r   <= ST_START;
        end
        ST_START: begin
          if (cnt_last_s) begin
            cnt_r   <= 16'd0;
            tx_r    <= shift_r[0];
            state_r <= ST_DATA;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_last_s) begin
            cnt_r <= 16'd0;
            if (bit_idx_r == LAST_IDX) begin
              if (PARITY_EN) begin
                tx_r    <= parity_r;
                state_r <= ST_PARITY;
              end else begin
                tx_r    <= 1'b1;
                state_r <= ST_STOP;
              end
            end else begin
              bit_idx_r <= bit_idx_r + IDX_ONE;
              shift_r   <= next_shift_s;
              tx_r      <= next_shift_s[0];
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_PARITY: begin
          if (cnt_last_s) begin
            cnt_r   <= 16'd0;
            tx_r    <= 1'b1;
            state_r <= ST_STOP;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_STOP: begin
          // Raised one edge early so the pulse lands on the last stop cycle.
          if (cnt_done_s) begin
            tx_done_r     <= 1'b1;
            frame_count_r <= frame_count_r + 16'd1;
          end
          if (cnt_last_s) begin
            cnt_r <= 16'd0;
            if (start_ok_s) begin
              state_r   <= ST_FETCH;
              fifo_rd_r <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 16'd0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo.fifo_rd = fifo_rd_r;
  assign tx           = tx_r;
  assign busy         = busy_r;
  assign tx_done      = tx_done_r;
  assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (parity off / on, 4 clocks per bit)
// each fed by a small registered-output FIFO model.
module tb_fifo_uart_tx;

  logic        clock;
  logic        reset;
  logic        tx_enable;
  logic        tx0, busy0, done0;
  logic        tx1, busy1, done1;
  logic [15:0] fc0, fc1;

  int pass_cnt = 0;
  int total_cnt = 0;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) if0 ();
  fifo_uart_tx_if #(.DATA_WIDTH(8)) if1 ();

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut0 (
    .clock(clock), .reset(reset), .tx_enable(tx_enable), .fifo(if0.master),
    .tx(tx0), .busy(busy0), .tx_done(done0), .frame_count(fc0)
  );

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
    .clock(clock), .reset(reset), .tx_enable(tx_enable), .fifo(if1.master),
    .tx(tx1), .busy(busy1), .tx_done(done1), .frame_count(fc1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // FIFO models: pointers into a byte store, data registered on the read strobe
  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  int bad_pop = 0;

  assign if0.fifo_empty = (wr0 == rd0);
  assign if1.fifo_empty = (wr1 == rd1);

  always @(posedge clock) begin
    if (if0.fifo_rd) begin
      if (wr0 == rd0) bad_pop <= bad_pop + 1;
      else begin
        if0.fifo_data <= mem0[rd0];
        rd0 <= rd0 + 1;
      end
    end
  end

  always @(posedge clock) begin
    if (if1.fifo_rd) begin
      if (wr1 == rd1) bad_pop <= bad_pop + 1;
      else begin
        if1.fifo_data <= mem1[rd1];
        rd1 <= rd1 + 1;
      end
    end
  end

  logic        tx_log   [0:399];
  logic        rd_log   [0:399];
  logic        done_log [0:399];
  logic        busy_log [0:399];
  logic [15:0] fc_log   [0:399];

  task automatic push(input int inst, input logic [7:0] b);
    if (inst == 0) begin
      mem0[wr0] = b;
      wr0 = wr0 + 1;
    end else begin
      mem1[wr1] = b;
      wr1 = wr1 + 1;
    end
  endtask

  // Called on a falling edge; logs one sample per cycle at each falling edge.
  task automatic record(input int inst, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      tx_log[start+i]   = (inst == 0) ? tx0 : tx1;
      rd_log[start+i]   = (inst == 0) ? if0.fifo_rd : if1.fifo_rd;
      done_log[start+i] = (inst == 0) ? done0 : done1;
      busy_log[start+i] = (inst == 0) ? busy0 : busy1;
      fc_log[start+i]   = (inst == 0) ? fc0 : fc1;
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [47:0] window(input int start, input int n);
    logic [47:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[i] = tx_log[start+i];
    return w;
  endfunction

  // Expected line waveform: each frame bit (bit 0 = start) held 4 cycles.
  function automatic logic [47:0] expand(input logic [11:0] f, input int nbits);
    logic [47:0] e;
    e = '0;
    for (int b = 0; b < nbits; b++)
      for (int j = 0; j < 4; j++) e[4*b+j] = f[b];
    return e;
  endfunction

  // which: 0 = fifo_rd highs, 1 = tx_done highs, 2 = busy highs, 3 = tx lows
  function automatic int count_log(input int which, input int start, input int n);
    int c;
    c = 0;
    for (int i = start; i < start + n; i++) begin
      case (which)
        0: c += (rd_log[i] === 1'b1) ? 1 : 0;
        1: c += (done_log[i] === 1'b1) ? 1 : 0;
        2: c += (busy_log[i] === 1'b1) ? 1 : 0;
        3: c += (tx_log[i] !== 1'b1) ? 1 : 0;
        default: c += 0;
      endcase
    end
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tx_enable = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total_cnt++;
    if (tx0 !== 1'b1) $display("FAIL reset_tx: got %b expected 1", tx0); else pass_cnt++;
    total_cnt++;
    if (if0.fifo_rd !== 1'b0) $display("FAIL reset_fifo_rd: got %b expected 0", if0.fifo_rd); else pass_cnt++;
    total_cnt++;
    if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy0); else pass_cnt++;
    total_cnt++;
    if (done0 !== 1'b0) $display("FAIL reset_tx_done: got %b expected 0", done0); else pass_cnt++;
    total_cnt++;
    if (fc0 !== 16'h0000) $display("FAIL reset_frame_count: got %h expected 0000", fc0); else pass_cnt++;
    total_cnt++;
    if ({tx1, if1.fifo_rd, busy1, done1, fc1} !== {4'b1000, 16'h0000})
      $display("FAIL reset_parity_inst: got %b expected %b", {tx1, if1.fifo_rd, busy1, done1, fc1}, {4'b1000, 16'h0000});
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_single_byte();
    logic [11:0] f;
    do_reset();
    tx_enable = 1'b1;
    push(0, 8'hA5);
    record(0, 0, 50);
    f = {2'b00, 1'b1, 8'hA5, 1'b0};
    total_cnt++;
    if (window(3, 40) !== expand(f, 10)) $display("FAIL single_frame: got %h expected %h", window(3, 40), expand(f, 10)); else pass_cnt++;
    total_cnt++;
    if ({tx_log[0], tx_log[1], tx_log[2]} !== 3'b111) $display("FAIL single_lead_idle: got %b expected 111", {tx_log[0], tx_log[1], tx_log[2]}); else pass_cnt++;
    total_cnt++;
    if (rd_log[1] !== 1'b1 || count_log(0, 0, 50) != 1) $display("FAIL single_fifo_rd: pulses %0d at1=%b expected 1 at cycle 1", count_log(0, 0, 50), rd_log[1]); else pass_cnt++;
    total_cnt++;
    if (done_log[42] !== 1'b1 || count_log(1, 0, 50) != 1) $display("FAIL single_tx_done: pulses %0d at42=%b expected 1 at cycle 42", count_log(1, 0, 50), done_log[42]); else pass_cnt++;
    total_cnt++;
    if (fc_log[41] !== 16'd0 || fc_log[42] !== 16'd1) $display("FAIL single_frame_count: got %0d->%0d expected 0->1", fc_log[41], fc_log[42]); else pass_cnt++;
    total_cnt++;
    if ({busy_log[0], busy_log[1], busy_log[42], busy_log[43]} !== 4'b0110)
      $display("FAIL single_busy: got %b expected 0110", {busy_log[0], busy_log[1], busy_log[42], busy_log[43]});
    else pass_cnt++;
  endtask

  task automatic test_parity();
    logic [11:0] fa, fb;
    do_reset();
    tx_enable = 1'b1;
    push(1, 8'hA5);
    push(1, 8'h07);
    record(1, 0, 100);
    fa = {1'b0, 1'b1, 1'b0, 8'hA5, 1'b0};
    fb = {1'b0, 1'b1, 1'b1, 8'h07, 1'b0};
    total_cnt++;
    if (window(3, 44) !== expand(fa, 11)) $display("FAIL parity_frame_a5: got %h expected %h", window(3, 44), expand(fa, 11)); else pass_cnt++;
    total_cnt++;
    if (window(49, 44) !== expand(fb, 11)) $display("FAIL parity_frame_07: got %h expected %h", window(49, 44), expand(fb, 11)); else pass_cnt++;
    total_cnt++;
    if ({tx_log[39], tx_log[85]} !== 2'b01) $display("FAIL parity_bits: got %b expected 01", {tx_log[39], tx_log[85]}); else pass_cnt++;
    total_cnt++;
    if (done_log[46] !== 1'b1 || done_log[92] !== 1'b1 || count_log(1, 0, 100) != 2)
      $display("FAIL parity_tx_done: pulses %0d at46=%b at92=%b expected 2 at 46,92", count_log(1, 0, 100), done_log[46], done_log[92]);
    else pass_cnt++;
    total_cnt++;
    if (rd_log[47] !== 1'b1 || count_log(0, 0, 100) != 2) $display("FAIL parity_fifo_rd: pulses %0d at47=%b expected 2", count_log(0, 0, 100), rd_log[47]); else pass_cnt++;
    total_cnt++;
    if (fc_log[99] !== 16'd2 || busy_log[99] !== 1'b0) $display("FAIL parity_end_state: count %0d busy %b expected 2 0", fc_log[99], busy_log[99]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] f;
    do_reset();
    tx_enable = 1'b1;
    for (int k = 0; k < 8; k++) push(0, 8'(k));
    record(0, 0, 345);
    for (int k = 0; k < 8; k++) begin
      f = {2'b00, 1'b1, 8'(k), 1'b0};
      total_cnt++;
      if (window(3 + 42*k, 40) !== expand(f, 10) || rd_log[1 + 42*k] !== 1'b1)
        $display("FAIL b2b_frame_%0d: got %h rd=%b expected %h rd=1", k, window(3 + 42*k, 40), rd_log[1 + 42*k], expand(f, 10));
      else pass_cnt++;
    end
    for (int k = 1; k < 8; k++) begin
      total_cnt++;
      if ({tx_log[42*k], tx_log[42*k+1], tx_log[42*k+2], tx_log[42*k+3]} !== 4'b1110)
        $display("FAIL b2b_gap_%0d: got %b expected 1110", k, {tx_log[42*k], tx_log[42*k+1], tx_log[42*k+2], tx_log[42*k+3]});
      else pass_cnt++;
    end
    total_cnt++;
    if (count_log(0, 0, 345) != 8 || count_log(1, 0, 345) != 8)
      $display("FAIL b2b_counts: rd %0d done %0d expected 8 8", count_log(0, 0, 345), count_log(1, 0, 345));
    else pass_cnt++;
    total_cnt++;
    if (if0.fifo_empty !== 1'b1 || busy_log[340] !== 1'b0 || fc_log[340] !== 16'd8)
      $display("FAIL b2b_end_state: empty %b busy %b count %0d expected 1 0 8", if0.fifo_empty, busy_log[340], fc_log[340]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    push(0, 8'hC3);
    record(0, 0, 20);
    total_cnt++;
    if (tx_log[19] !== 1'b0 || busy_log[19] !== 1'b1) $display("FAIL midrst_pre: tx %b busy %b expected 0 1", tx_log[19], busy_log[19]); else pass_cnt++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    total_cnt++;
    if ({tx0, busy0, if0.fifo_rd, done0} !== 4'b1000) $display("FAIL midrst_outputs: got %b expected 1000", {tx0, busy0, if0.fifo_rd, done0}); else pass_cnt++;
    total_cnt++;
    if (fc0 !== 16'd0) $display("FAIL midrst_frame_count: got %0d expected 0", fc0); else pass_cnt++;
    record(0, 0, 60);
    total_cnt++;
    if (count_log(1, 0, 60) != 0 || count_log(0, 0, 60) != 0 || count_log(3, 0, 60) != 0 || count_log(2, 0, 60) != 0)
      $display("FAIL midrst_quiet: done %0d rd %0d txlow %0d busy %0d expected 0 0 0 0",
               count_log(1, 0, 60), count_log(0, 0, 60), count_log(3, 0, 60), count_log(2, 0, 60));
    else pass_cnt++;
  endtask

  task automatic test_enable_gating();
    logic [11:0] f;
    do_reset();
    tx_enable = 1'b1;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    record(0, 0, 15);
    tx_enable = 1'b0;
    record(0, 15, 105);
    f = {2'b00, 1'b1, 8'h11, 1'b0};
    total_cnt++;
    if (window(3, 40) !== expand(f, 10) || done_log[42] !== 1'b1) $display("FAIL gate_frame1: got %h done %b expected %h done 1", window(3, 40), done_log[42], expand(f, 10)); else pass_cnt++;
    total_cnt++;
    if (count_log(0, 0, 120) != 1 || busy_log[119] !== 1'b0 || if0.fifo_empty !== 1'b0)
      $display("FAIL gate_held: rd %0d busy %b empty %b expected 1 0 0", count_log(0, 0, 120), busy_log[119], if0.fifo_empty);
    else pass_cnt++;
    tx_enable = 1'b1;
    record(0, 0, 90);
    total_cnt++;
    if ({rd_log[1], tx_log[2], tx_log[3]} !== 3'b110) $display("FAIL gate_restart: got %b expected 110", {rd_log[1], tx_log[2], tx_log[3]}); else pass_cnt++;
    f = {2'b00, 1'b1, 8'h22, 1'b0};
    total_cnt++;
    if (window(3, 40) !== expand(f, 10)) $display("FAIL gate_frame2: got %h expected %h", window(3, 40), expand(f, 10)); else pass_cnt++;
    f = {2'b00, 1'b1, 8'h33, 1'b0};
    total_cnt++;
    if (window(45, 40) !== expand(f, 10)) $display("FAIL gate_frame3: got %h expected %h", window(45, 40), expand(f, 10)); else pass_cnt++;
    total_cnt++;
    if (fc_log[89] !== 16'd3 || busy_log[89] !== 1'b0) $display("FAIL gate_end_state: count %0d busy %b expected 3 0", fc_log[89], busy_log[89]); else pass_cnt++;
  endtask

  task automatic test_empty_fifo();
    do_reset();
    tx_enable = 1'b1;
    record(0, 0, 100);
    total_cnt++;
    if (count_log(0, 0, 100) != 0 || count_log(3, 0, 100) != 0 || count_log(2, 0, 100) != 0)
      $display("FAIL empty_idle: rd %0d txlow %0d busy %0d expected 0 0 0", count_log(0, 0, 100), count_log(3, 0, 100), count_log(2, 0, 100));
    else pass_cnt++;
    total_cnt++;
    if (bad_pop != 0) $display("FAIL empty_pop: got %0d pops of empty FIFO expected 0", bad_pop); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    tx_enable = 1'b0;
    test_reset();
    test_single_byte();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_enable_gating();
    test_empty_fifo();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
